// File: rtl/led_frame_controller.sv
// Double-buffered 8x8 red/green frame store with row-scan timing.
// Game logic draws into the back buffer; commits swap buffers only on a frame boundary.
module led_frame_controller #(
  parameter int SCAN_DIV     = 1000,
  parameter bit COPY_ON_SWAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_red,
  input  logic [7:0] wr_green,
  output logic       wr_ready,
  input  logic       commit,
  output logic       commit_ready,
  output logic       commit_done,
  output logic [7:0] red_array   [8],
  output logic [7:0] green_array [8],
  output logic       scan_tick,
  output logic [2:0] row_index,
  output logic       frame_start
);

  localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COPY} state_t;

  state_t        r_state;
  logic [PW-1:0] r_prescale;
  logic [2:0]    r_row;
  logic          r_front_sel;
  logic [2:0]    r_copy_idx;
  logic          r_commit_done;
  logic [7:0]    r_red   [2][8];
  logic [7:0]    r_green [2][8];

  logic w_scan_tick;
  logic w_frame_start;
  logic w_back_sel;
  logic w_idle;

  assign w_scan_tick   = (r_prescale == PS_LAST);
  assign w_frame_start = w_scan_tick && (r_row == 3'd7);
  assign w_back_sel    = ~r_front_sel;
  assign w_idle        = (r_state == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
      r_row      <= '0;
    end else if (w_scan_tick) begin
      r_prescale <= '0;
      r_row      <= r_row + 3'd1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_front_sel   <= 1'b0;
      r_copy_idx    <= '0;
      r_commit_done <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          r_red[b][r]   <= '0;
          r_green[b][r] <= '0;
        end
      end
    end else begin
      r_commit_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_en) begin
            r_red[w_back_sel][wr_row]   <= wr_red;
            r_green[w_back_sel][wr_row] <= wr_green;
          end
          // A commit seen on the boundary edge itself is only armed here, so it waits a full frame.
          if (commit) r_state <= S_PENDING;
        end
        S_PENDING: begin
          if (w_frame_start) begin
            r_front_sel   <= ~r_front_sel;
            r_commit_done <= 1'b1;
            r_copy_idx    <= '0;
            r_state       <= COPY_ON_SWAP ? S_COPY : S_IDLE;
          end
        end
        S_COPY: begin
          r_red[w_back_sel][r_copy_idx]   <= r_red[r_front_sel][r_copy_idx];
          r_green[w_back_sel][r_copy_idx] <= r_green[r_front_sel][r_copy_idx];
          r_copy_idx                      <= r_copy_idx + 3'd1;
          if (r_copy_idx == 3'd7) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_front
    assign red_array[gi]   = r_red[r_front_sel][gi];
    assign green_array[gi] = r_green[r_front_sel][gi];
  end

  assign wr_ready     = w_idle;
  assign commit_ready = w_idle;
  assign commit_done  = r_commit_done;
  assign scan_tick    = w_scan_tick;
  assign row_index    = r_row;
  assign frame_start  = w_frame_start;

endmodule

// File: tb/tb_led_frame_controller.sv
// Directed bench for led_frame_controller with SCAN_DIV=4 (32-clock frames) and copy-on-swap.
module tb_led_frame_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_red = '0;
  logic [7:0] wr_green = '0;
  logic       wr_ready;
  logic       commit = 1'b0;
  logic       commit_ready;
  logic       commit_done;
  logic [7:0] red_array   [8];
  logic [7:0] green_array [8];
  logic       scan_tick;
  logic [2:0] row_index;
  logic       frame_start;

  int n_cmp = 0;
  int n_err = 0;

  led_frame_controller #(.SCAN_DIV(4), .COPY_ON_SWAP(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_red       (wr_red),
    .wr_green     (wr_green),
    .wr_ready     (wr_ready),
    .commit       (commit),
    .commit_ready (commit_ready),
    .commit_done  (commit_done),
    .red_array    (red_array),
    .green_array  (green_array),
    .scan_tick    (scan_tick),
    .row_index    (row_index),
    .frame_start  (frame_start)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_frame_start(output bit ok);
    int n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    ok = (frame_start === 1'b1);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    ok = (wr_ready === 1'b1);
  endtask

  task automatic test_reset();
    bit zero_ok;
    reset = 1'b0;
    repeat (3) step();
    zero_ok = 1'b1;
    for (int k = 0; k < 8; k++)
      if (red_array[k] !== 8'h00 || green_array[k] !== 8'h00) zero_ok = 1'b0;
    n_cmp++;
    if (!zero_ok) begin n_err++; $display("FAIL reset_arrays: front buffer not all zero"); end
    n_cmp++;
    if ({scan_tick, frame_start, commit_done, wr_ready, commit_ready, row_index} !== {5'b00011, 3'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got tick=%b fs=%b done=%b wr_rdy=%b c_rdy=%b row=%0d, expected 0 0 0 1 1 0",
               scan_tick, frame_start, commit_done, wr_ready, commit_ready, row_index);
    end
    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      n_cmp++;
      if (scan_tick !== ((k % 4) == 3) || row_index !== 3'((k / 4) % 8) || frame_start !== ((k % 32) == 31)) begin
        n_err++;
        $display("FAIL scan_timing k=%0d: got tick=%b row=%0d fs=%b, expected tick=%b row=%0d fs=%b",
                 k, scan_tick, row_index, frame_start, (k % 4) == 3, (k / 4) % 8, (k % 32) == 31);
      end
      step();
    end
    $display("test_reset done");
  endtask

  task automatic test_write_commit();
    bit ok;
    bit stayed_zero;
    int n;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_row = 3'(k); wr_red = 8'h01 << k; wr_green = 8'h80 >> k;
      step();
    end
    wr_row = 3'd6; wr_red = 8'h5A; wr_green = 8'h5A;
    step();
    wr_red = 8'h40; wr_green = 8'h02;
    step();
    wr_en = 1'b0;
    n = 0;
    while (row_index !== 3'd3 && n < 64) begin step(); n++; end
    commit = 1'b1;
    step();
    commit = 1'b0;
    n_cmp++;
    if (wr_ready !== 1'b0 || commit_ready !== 1'b0) begin
      n_err++; $display("FAIL pending_ready: got wr=%b commit=%b, expected 0 0", wr_ready, commit_ready);
    end
    stayed_zero = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      for (int k = 0; k < 8; k++) if (red_array[k] !== 8'h00) stayed_zero = 1'b0;
      step();
      n++;
    end
    for (int k = 0; k < 8; k++) if (red_array[k] !== 8'h00) stayed_zero = 1'b0;
    n_cmp++;
    if (n >= 64 || !stayed_zero) begin
      n_err++; $display("FAIL early_swap: front changed before boundary (stayed_zero=%b waited=%0d)", stayed_zero, n);
    end
    step();
    n_cmp++;
    if (row_index !== 3'd0 || commit_done !== 1'b1) begin
      n_err++; $display("FAIL swap_edge: got row=%0d done=%b, expected row=0 done=1", row_index, commit_done);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (red_array[k] !== (8'h01 << k) || green_array[k] !== (8'h80 >> k)) begin
        n_err++;
        $display("FAIL swap_row%0d: got red=%h green=%h, expected red=%h green=%h",
                 k, red_array[k], green_array[k], 8'h01 << k, 8'h80 >> k);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wr_ready !== 1'b0 || commit_done !== (i == 0)) begin
        n_err++; $display("FAIL copy_cycle%0d: got wr_ready=%b done=%b, expected 0 %b", i, wr_ready, commit_done, i == 0);
      end
      step();
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL copy_end: got wr_ready=%b, expected 1", wr_ready); end
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_frame_start(ok);
    step();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (!ok || red_array[k] !== (8'h01 << k) || green_array[k] !== (8'h80 >> k)) begin
        n_err++;
        $display("FAIL copied_row%0d: got red=%h green=%h, expected red=%h green=%h",
                 k, red_array[k], green_array[k], 8'h01 << k, 8'h80 >> k);
      end
    end
    wait_idle(ok);
    $display("test_write_commit done");
  endtask

  task automatic test_write_with_commit();
    bit ok;
    wr_en = 1'b1; wr_row = 3'd5; wr_red = 8'hAA; wr_green = 8'h55; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    wait_frame_start(ok);
    step();
    n_cmp++;
    if (!ok || red_array[5] !== 8'hAA || green_array[5] !== 8'h55 || red_array[4] !== 8'h10) begin
      n_err++;
      $display("FAIL write_with_commit: got red5=%h green5=%h red4=%h, expected AA 55 10",
               red_array[5], green_array[5], red_array[4]);
    end
    wait_idle(ok);
    $display("test_write_with_commit done");
  endtask

  task automatic test_commit_on_frame_start();
    bit ok;
    int n;
    wr_en = 1'b1; wr_row = 3'd0; wr_red = 8'hC3; wr_green = 8'h3C;
    step();
    wr_en = 1'b0;
    wait_frame_start(ok);
    commit = 1'b1;
    step();
    commit = 1'b0;
    n_cmp++;
    if (!ok || red_array[0] !== 8'h01 || commit_ready !== 1'b0 || commit_done !== 1'b0) begin
      n_err++;
      $display("FAIL fs_commit_no_swap: got red0=%h c_rdy=%b done=%b, expected 01 0 0", red_array[0], commit_ready, commit_done);
    end
    n = 0;
    while (frame_start !== 1'b1 && n < 64) begin step(); n++; end
    n_cmp++;
    if (n !== 31) begin n_err++; $display("FAIL fs_commit_latency: got %0d cycles to boundary, expected 31", n); end
    step();
    n_cmp++;
    if (red_array[0] !== 8'hC3 || green_array[0] !== 8'h3C || commit_done !== 1'b1) begin
      n_err++;
      $display("FAIL fs_commit_swap: got red0=%h green0=%h done=%b, expected C3 3C 1", red_array[0], green_array[0], commit_done);
    end
    wait_idle(ok);
    $display("test_commit_on_frame_start done");
  endtask

  task automatic test_pending_ignored();
    bit ok;
    int dones;
    commit = 1'b1;
    step();
    commit = 1'b0;
    wr_en = 1'b1; wr_row = 3'd2; wr_red = 8'hFF; wr_green = 8'hFF; commit = 1'b1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL pending_wr_ready: got %b, expected 0", wr_ready); end
    step();
    wr_en = 1'b0; commit = 1'b0;
    wait_frame_start(ok);
    step();
    n_cmp++;
    if (!ok || red_array[2] !== 8'h04 || green_array[2] !== 8'h20 || commit_done !== 1'b1) begin
      n_err++;
      $display("FAIL pending_write_ignored: got red2=%h green2=%h done=%b, expected 04 20 1", red_array[2], green_array[2], commit_done);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (commit_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || red_array[2] !== 8'h04) begin
      n_err++; $display("FAIL pending_commit_ignored: got %0d extra done pulses red2=%h, expected 0 04", dones, red_array[2]);
    end
    $display("test_pending_ignored done");
  endtask

  task automatic test_reset_during_copy();
    bit ok;
    bit zero_ok;
    wait_idle(ok);
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_frame_start(ok);
    step();
    repeat (3) step();
    n_cmp++;
    if (!ok || wr_ready !== 1'b0 || red_array[5] !== 8'hAA) begin
      n_err++; $display("FAIL copy_precondition: got wr_ready=%b red5=%h, expected 0 AA", wr_ready, red_array[5]);
    end
    reset = 1'b0;
    #1;
    zero_ok = 1'b1;
    for (int k = 0; k < 8; k++)
      if (red_array[k] !== 8'h00 || green_array[k] !== 8'h00) zero_ok = 1'b0;
    n_cmp++;
    if (!zero_ok || wr_ready !== 1'b1 || commit_ready !== 1'b1 || row_index !== 3'd0 || commit_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_copy: got zero=%b wr=%b c_rdy=%b row=%0d done=%b, expected 1 1 1 0 0",
               zero_ok, wr_ready, commit_ready, row_index, commit_done);
    end
    step();
    reset = 1'b1;
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_frame_start(ok);
    step();
    zero_ok = 1'b1;
    for (int k = 0; k < 8; k++)
      if (red_array[k] !== 8'h00 || green_array[k] !== 8'h00) zero_ok = 1'b0;
    n_cmp++;
    if (!ok || !zero_ok || commit_done !== 1'b1) begin
      n_err++; $display("FAIL post_reset_commit: got zero=%b done=%b, expected 1 1", zero_ok, commit_done);
    end
    $display("test_reset_during_copy done");
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_write_with_commit();
    test_commit_on_frame_start();
    test_pending_ignored();
    test_reset_during_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_frame_controller.md
Name: led_frame_controller

Overview:
- Double-buffered frame controller feeding the 8x8 red/green LED matrix driver.
- Game logic writes rows into a back buffer. On commit, the controller swaps front and back buffers at the next frame boundary, so a partially drawn frame is never scanned.
- Generates the row-scan tick and frame-boundary timing. Optionally copies the new front frame into the back buffer so drawing can be incremental.

Parameters:
- SCAN_DIV, 1000, clocks per displayed row (scan_tick period); legal range >= 2.
- COPY_ON_SWAP, 1, 1 = copy front into back after each swap; 0 = back keeps its old contents.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  row write request.
- wr_row  input  3  target row in back buffer.
- wr_red  input  8  red bits for wr_row.
- wr_green  input  8  green bits for wr_row.
- wr_ready  output  1  write accepted when wr_en & wr_ready.
- commit  input  1  request swap at the next frame boundary.
- commit_ready  output  1  commit accepted when commit & commit_ready.
- commit_done  output  1  one-cycle pulse in the first cycle the new frame is displayed.
- red_array  output  8x[7:0]  front-buffer red rows, to driver.
- green_array  output  8x[7:0]  front-buffer green rows, to driver.
- scan_tick  output  1  one-cycle pulse per row period.
- row_index  output  3  current scanned row.
- frame_start  output  1  equals scan_tick & (row_index==7).

Behaviour:
- Reset (async assert):
  - Both buffers cleared to 0, front select = 0, state IDLE, prescaler = 0, row_index = 0.
  - Outputs: red_array/green_array all 0, scan_tick 0, frame_start 0, commit_done 0, wr_ready 1, commit_ready 1.
  - Reset mid-PENDING or mid-COPY abandons the operation entirely.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps. scan_tick is high combinationally while the count equals SCAN_DIV-1.
  - row_index increments mod 8 on each clock edge where scan_tick is high (7 wraps to 0).
- States:
  - IDLE: wr_ready = 1, commit_ready = 1. An accepted write updates back[wr_row] at the clock edge. An accepted commit moves to PENDING.
  - PENDING: wr_ready = 0, commit_ready = 0. At the edge where frame_start = 1, front select toggles. The new data appears on red_array/green_array at the same edge row_index becomes 0. Next state is COPY if COPY_ON_SWAP = 1, else IDLE. commit_done is registered high for exactly the following cycle.
  - COPY: wr_ready = 0, commit_ready = 0. Runs 8 cycles, copying front row k to back row k for k = 0..7 in order, then returns to IDLE.
- Simultaneous events:
  - wr_en and commit in the same IDLE cycle: the write lands in the back buffer and is included in the swap.
  - A commit accepted in the same cycle as frame_start does not swap at that boundary; the swap waits for the next one.
  - Latency from commit acceptance to swap: at most 8*SCAN_DIV clocks, at least 1.
  - commit while not IDLE: ignored, no queueing.
  - wr_en while wr_ready = 0: ignored; the requester must hold the request.
  - Writes to the same row in consecutive cycles: last write wins.
- Front buffer: never modified except by the swap; outputs change only at frame boundaries.
- SCAN_DIV width: derived via $clog2(SCAN_DIV).

Test Plan:
(All scenarios use SCAN_DIV=4, COPY_ON_SWAP=1; frame = 32 clocks.)
- Reset check: hold reset low 3 cycles -> all outputs at reset values. Release -> scan_tick every 4th clock, row_index 0..7 cyclic, frame_start every 32 clocks on the row 7 tick.
- Write rows 0..7 with red=8'h01<<k, green=8'h80>>k, then commit mid-frame at row 3 -> red_array stays 0 until the frame_start edge. Then red_array[k]=8'h01<<k with row_index=0, commit_done pulses once, wr_ready low for 8 cycles (COPY), back buffer equals front.
- Write plus commit in the same IDLE cycle (row 5, red=8'hAA) -> red_array[5]=8'hAA after the next boundary.
- Commit on the exact frame_start cycle -> no swap at that boundary; swap occurs 32 clocks later.
- During PENDING, pulse wr_en (row 2, 8'hFF) and a second commit -> both ignored. Back row 2 is unchanged and only one commit_done occurs.
- Assert reset during COPY (cycle 4 of 8) -> buffers zero, state IDLE, wr_ready=1 immediately. The next commit displays all-zero rows.
